// File: rtl/wave_gen.sv
// wave_gen: prescaled saw / triangle / square waveform generator.
// Mode and amplitude are captured into shadow registers while disabled and
// at every period boundary, so a running waveform never changes shape
// mid-period. The prescaler is read live.
module wave_gen #(
    parameter int DATA_W  = 16,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [1:0]         mode,
    input  logic [DATA_W-1:0]  amplitude,
    input  logic [PRESC_W-1:0] prescaler,
    output logic [DATA_W-1:0]  data,
    output logic               period_tick,
    output logic               o_dbg_dir,
    output logic [1:0]         o_dbg_mode_s,
    output logic [DATA_W-1:0]  o_dbg_amp_s
);

    typedef enum logic [1:0] {
        MODE_SAW = 2'b00,
        MODE_TRI = 2'b01,
        MODE_SQR = 2'b10,
        MODE_RSV = 2'b11
    } mode_t;

    // Triangle slope direction; the only piece of sequencing state besides
    // the phase counter.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Registered state
    logic [PRESC_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_phase;
    dir_t               r_dir;
    logic [DATA_W-1:0]  r_data;
    logic               r_tick;
    mode_t              r_mode_s;
    logic [DATA_W-1:0]  r_amp_s;

    // Step strobe and per-waveform next values
    logic               w_cnt_hit;
    logic [DATA_W:0]    w_half;

    logic [DATA_W-1:0]  w_saw_data;
    logic               w_saw_wrap;

    logic [DATA_W-1:0]  w_tri_data;
    dir_t               w_tri_dir;
    logic               w_tri_wrap;

    logic [DATA_W-1:0]  w_sqr_phase;
    logic [DATA_W-1:0]  w_sqr_data;
    logic               w_sqr_wrap;

    logic [DATA_W-1:0]  w_data_nxt;
    logic [DATA_W-1:0]  w_phase_nxt;
    dir_t               w_dir_nxt;
    logic               w_wrap;

    // A step happens on the clock where the tick counter equals P.
    assign w_cnt_hit = (r_cnt == prescaler);

    // Square high-time threshold, one bit wider so an all-ones amplitude
    // cannot wrap (A+1) to zero.
    assign w_half = ({1'b0, r_amp_s} + (DATA_W+1)'(1)) >> 1;

    // Saw: ramp up by one, wrap to zero once at or above the peak.
    always_comb begin
        w_saw_data = r_data + DATA_W'(1);
        w_saw_wrap = 1'b0;
        if (r_data >= r_amp_s) begin
            w_saw_data = '0;
            w_saw_wrap = 1'b1;
        end
    end

    // Triangle: climb while below the peak, then descend; reaching zero on
    // the way down (or sitting at zero with a zero peak) ends the period.
    always_comb begin
        w_tri_data = r_data;
        w_tri_dir  = r_dir;
        w_tri_wrap = 1'b0;
        if (r_dir == DIR_UP && r_data < r_amp_s) begin
            w_tri_data = r_data + DATA_W'(1);
            w_tri_dir  = DIR_UP;
        end else if (r_data <= DATA_W'(1)) begin
            w_tri_data = '0;
            w_tri_dir  = DIR_UP;
            w_tri_wrap = 1'b1;
        end else begin
            w_tri_data = r_data - DATA_W'(1);
            w_tri_dir  = DIR_DOWN;
        end
    end

    // Square: phase counts 0..A like the saw; output is high for phase < H.
    always_comb begin
        w_sqr_phase = r_phase + DATA_W'(1);
        w_sqr_wrap  = 1'b0;
        if (r_phase >= r_amp_s) begin
            w_sqr_phase = '0;
            w_sqr_wrap  = 1'b1;
        end
        w_sqr_data = ({1'b0, w_sqr_phase} < w_half) ? r_amp_s : '0;
    end

    // Select the next sample from the shadowed mode. Non-square modes keep
    // the phase at zero and non-triangle modes keep the direction up, so a
    // mode change at a boundary always starts clean.
    always_comb begin
        w_data_nxt  = '0;
        w_phase_nxt = '0;
        w_dir_nxt   = DIR_UP;
        w_wrap      = 1'b1;
        case (r_mode_s)
            MODE_SAW: begin
                w_data_nxt = w_saw_data;
                w_wrap     = w_saw_wrap;
            end
            MODE_TRI: begin
                w_data_nxt = w_tri_data;
                w_dir_nxt  = w_tri_dir;
                w_wrap     = w_tri_wrap;
            end
            MODE_SQR: begin
                w_data_nxt  = w_sqr_data;
                w_phase_nxt = w_sqr_phase;
                w_wrap      = w_sqr_wrap;
            end
            default: begin
                // Reserved: flat zero, every step is a period boundary.
                w_data_nxt  = '0;
                w_phase_nxt = '0;
                w_wrap      = 1'b1;
            end
        endcase
    end

    // Prescaler, waveform state, shadow capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_phase  <= '0;
            r_dir    <= DIR_UP;
            r_data   <= '0;
            r_tick   <= 1'b0;
            r_mode_s <= MODE_SAW;
            r_amp_s  <= '0;
        end else if (!ena) begin
            // Idle: data holds, everything else is parked and the shadows
            // track the inputs so the next enable uses fresh settings.
            r_cnt    <= '0;
            r_phase  <= '0;
            r_dir    <= DIR_UP;
            r_tick   <= 1'b0;
            r_mode_s <= mode_t'(mode);
            r_amp_s  <= amplitude;
        end else if (w_cnt_hit) begin
            r_cnt  <= '0;
            r_data <= w_data_nxt;
            r_tick <= w_wrap;
            if (w_wrap) begin
                r_phase  <= '0;
                r_dir    <= DIR_UP;
                r_mode_s <= mode_t'(mode);
                r_amp_s  <= amplitude;
            end else begin
                r_phase <= w_phase_nxt;
                r_dir   <= w_dir_nxt;
            end
        end else begin
            r_cnt  <= r_cnt + PRESC_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign data         = r_data;
    assign period_tick  = r_tick;
    assign o_dbg_dir    = r_dir;
    assign o_dbg_mode_s = r_mode_s;
    assign o_dbg_amp_s  = r_amp_s;

endmodule
